align_phase_sequencer: RTL and testbench

Job-level controller for the DNA alignment datapath. Accepts one alignment job at a time over a valid/ready handshake. Sequences the four datapath phases (create, initialize, traceback, verdict) with one-cycle start pulses, waits for each phase's done, and guards every phase with a watchdog. Returns a tagged result record (status, match, score) over a second valid/ready handshake.

---
 rtl/align_pkg.sv | 50 +++++
 rtl/phase_watchdog.sv | 48 ++++
 rtl/align_phase_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_align_phase_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/align_pkg.sv
// ---------------------------------------------------------------------------
// align_pkg
//   Shared types and defaults for the alignment job sequencer and its
//   helpers.
//   - phase_state_e   : sequencer state encoding, also visible on cur_phase
//   - result_status_e : completion status carried in the result record
//   - *_DEF           : default widths for the sequencer parameters
//   - is_phase()      : true for the four datapath phase states
//   - next_phase()    : successor of a phase state on normal completion
// ---------------------------------------------------------------------------
package align_pkg;

    localparam int ID_W_DEF    = 8;
    localparam int SCORE_W_DEF = 16;
    localparam int TO_W_DEF    = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CREATE  = 3'd1,
        S_INIT    = 3'd2,
        S_TRACE   = 3'd3,
        S_VERDICT = 3'd4,
        S_REPORT  = 3'd5
    } phase_state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_ABORTED = 2'd2
    } result_status_e;

    function automatic logic is_phase(input phase_state_e s);
        return (s == S_CREATE) || (s == S_INIT) ||
               (s == S_TRACE)  || (s == S_VERDICT);
    endfunction

    // Successor after a phase reports done; VERDICT hands off to REPORT.
    function automatic phase_state_e next_phase(input phase_state_e s);
        phase_state_e n;
        case (s)
            S_CREATE:  n = S_INIT;
            S_INIT:    n = S_TRACE;
            S_TRACE:   n = S_VERDICT;
            S_VERDICT: n = S_REPORT;
            default:   n = S_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// ---------------------------------------------------------------------------
// phase_watchdog
//   Cycle counter guarding one engine phase.
//   Ports:
//     clk, reset : system clock, synchronous active-high reset
//     clear      : forces the count to 0 on the next edge (wins over enable)
//     enable     : count up by one per cycle while high
//     limit      : cycle limit; 0 disables expiry
//     expired    : high while enabled and the registered count equals limit
//   expired is decoded from the registered count and the limit only, so a
//   caller may let a same-cycle done take priority over it.
//   The counter wraps; with a nonzero limit it always reaches the limit
//   before wrapping, and with limit 0 the wrapped value is never used.
// ---------------------------------------------------------------------------
module phase_watchdog #(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (limit != '0) && (count_q == limit);

endmodule

// File: rtl/align_phase_sequencer.sv
// ---------------------------------------------------------------------------
// align_phase_sequencer
//   Job-level controller for the alignment datapath. Accepts one job at a
//   time, runs CREATE -> INIT -> TRACE -> VERDICT with one-cycle start
//   pulses, guards each phase with a watchdog and returns a tagged result.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both high. job_ready is high only in S_IDLE; result_valid is
//   high only in S_REPORT and the result fields hold steady until the edge
//   where result_ready is also high.
//
//   Ports:
//     clk, reset                    clock, synchronous active-high reset
//     job_valid/job_ready/job_id    job request channel
//     cfg_timeout                   per-phase cycle limit (0 = no watchdog)
//     abort                         host abort, sampled in phase states
//     *_start                       one-cycle phase start pulses
//     fcreate..fverdict             phase done flags
//     verdict_match/verdict_score   verdict data, valid with fverdict
//     phase_abort                   one-cycle kill pulse to the active engine
//     busy, cur_phase               status / registered state
//     result_*                      result record channel
//     jobs_done                     saturating count of delivered results
//
//   Every output is a flop or a decode of the registered state.
// ---------------------------------------------------------------------------
module align_phase_sequencer
    import align_pkg::*;
#(
    parameter int ID_W    = ID_W_DEF,
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [ID_W-1:0]    job_id,
    input  logic [TO_W-1:0]    cfg_timeout,
    input  logic               abort,
    output logic               create_start,
    output logic               init_start,
    output logic               trace_start,
    output logic               verdict_start,
    input  logic               fcreate,
    input  logic               finitialize,
    input  logic               ftraceback,
    input  logic               fverdict,
    input  logic               verdict_match,
    input  logic [SCORE_W-1:0] verdict_score,
    output logic               phase_abort,
    output logic               busy,
    output logic [2:0]         cur_phase,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [ID_W-1:0]    result_id,
    output logic [1:0]         result_status,
    output logic               result_match,
    output logic [SCORE_W-1:0] result_score,
    output logic [15:0]        jobs_done
);

    phase_state_e       state_q,  state_d;
    logic [ID_W-1:0]    id_q,     id_d;
    logic [TO_W-1:0]    to_q,     to_d;
    result_status_e     status_q, status_d;
    logic               match_q,  match_d;
    logic [SCORE_W-1:0] score_q,  score_d;
    logic [15:0]        jobs_q,   jobs_d;
    logic [3:0]         start_q,  start_d;   // {verdict, trace, init, create}
    logic               kill_q,   kill_d;

    logic phase_done;
    logic in_entry;
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    // Exactly one start bit is high in a phase's first cycle, so it doubles
    // as the "ignore done this cycle" marker.
    assign in_entry = |start_q;

    // Restart the watchdog on every state change so it reads 0 in each
    // phase's entry cycle.
    assign wd_clear  = (state_d != state_q);
    assign wd_enable = is_phase(state_q);

    phase_watchdog #(
        .TO_W (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .limit   (to_q),
        .expired (wd_expired)
    );

    // Done flag of the active phase; the others are ignored.
    always_comb begin
        phase_done = 1'b0;
        case (state_q)
            S_CREATE:  phase_done = fcreate;
            S_INIT:    phase_done = finitialize;
            S_TRACE:   phase_done = ftraceback;
            S_VERDICT: phase_done = fverdict;
            default:   phase_done = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register (all flops)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            to_q     <= '0;
            status_q <= ST_OK;
            match_q  <= 1'b0;
            score_q  <= '0;
            jobs_q   <= '0;
            start_q  <= '0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            to_q     <= to_d;
            status_q <= status_d;
            match_q  <= match_d;
            score_q  <= score_d;
            jobs_q   <= jobs_d;
            start_q  <= start_d;
            kill_q   <= kill_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and record update
    // Priority inside a phase: abort > done (after entry) > watchdog.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        to_d     = to_q;
        status_d = status_q;
        match_d  = match_q;
        score_d  = score_q;
        jobs_d   = jobs_q;
        kill_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    id_d     = job_id;
                    to_d     = cfg_timeout;
                    status_d = ST_OK;
                    match_d  = 1'b0;
                    score_d  = '0;
                    state_d  = S_CREATE;
                end
            end

            S_CREATE, S_INIT, S_TRACE, S_VERDICT: begin
                if (abort) begin
                    status_d = ST_ABORTED;
                    kill_d   = 1'b1;
                    state_d  = S_REPORT;
                end else if (!in_entry && phase_done) begin
                    if (state_q == S_VERDICT) begin
                        match_d  = verdict_match;
                        score_d  = verdict_score;
                        status_d = ST_OK;
                    end
                    state_d = next_phase(state_q);
                end else if (wd_expired) begin
                    status_d = ST_TIMEOUT;
                    kill_d   = 1'b1;
                    state_d  = S_REPORT;
                end
            end

            S_REPORT: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                    if (jobs_q != 16'hFFFF) begin
                        jobs_d = jobs_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Start pulse for the phase being entered, registered so it lines up
    // with the first cycle spent in that phase.
    always_comb begin
        start_d = '0;
        if (state_d != state_q) begin
            case (state_d)
                S_CREATE:  start_d = 4'b0001;
                S_INIT:    start_d = 4'b0010;
                S_TRACE:   start_d = 4'b0100;
                S_VERDICT: start_d = 4'b1000;
                default:   start_d = '0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        job_ready     = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE);
        cur_phase     = state_q;
        result_valid  = (state_q == S_REPORT);
        create_start  = start_q[0];
        init_start    = start_q[1];
        trace_start   = start_q[2];
        verdict_start = start_q[3];
        phase_abort   = kill_q;
        result_id     = id_q;
        result_status = status_q;
        result_match  = match_q;
        result_score  = score_q;
        jobs_done     = jobs_q;
    end

endmodule

// File: tb/tb_align_phase_sequencer.sv
module tb_align_phase_sequencer;

  localparam int ID_W    = 8;
  localparam int SCORE_W = 16;
  localparam int TO_W    = 16;

  // ------------------------------------------------------------------
  // Clock / reset
  // ------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               job_valid = 1'b0;
  logic               job_ready;
  logic [ID_W-1:0]    job_id = '0;
  logic [TO_W-1:0]    cfg_timeout = '0;
  logic               abort = 1'b0;
  logic               create_start, init_start, trace_start, verdict_start;
  logic               fcreate = 1'b0, finitialize = 1'b0, ftraceback = 1'b0, fverdict = 1'b0;
  logic               verdict_match = 1'b0;
  logic [SCORE_W-1:0] verdict_score = '0;
  logic               phase_abort;
  logic               busy;
  logic [2:0]         cur_phase;
  logic               result_valid;
  logic               result_ready = 1'b0;
  logic [ID_W-1:0]    result_id;
  logic [1:0]         result_status;
  logic               result_match;
  logic [SCORE_W-1:0] result_score;
  logic [15:0]        jobs_done;

  align_phase_sequencer #(.ID_W(ID_W), .SCORE_W(SCORE_W), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
    .cfg_timeout(cfg_timeout), .abort(abort),
    .create_start(create_start), .init_start(init_start),
    .trace_start(trace_start), .verdict_start(verdict_start),
    .fcreate(fcreate), .finitialize(finitialize),
    .ftraceback(ftraceback), .fverdict(fverdict),
    .verdict_match(verdict_match), .verdict_score(verdict_score),
    .phase_abort(phase_abort), .busy(busy), .cur_phase(cur_phase),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_status(result_status),
    .result_match(result_match), .result_score(result_score),
    .jobs_done(jobs_done)
  );

  // ------------------------------------------------------------------
  // Scoreboard counters
  // ------------------------------------------------------------------
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s wait budget expired cyc=%0d", name, cyc);
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: job phase index 0..5 (idle, four phases, report)
  // and the number of cycles spent in the current phase.
  // ------------------------------------------------------------------
  int m_ph = 0, m_age = 0;
  bit m_pa = 0;
  int m_id = 0, m_to = 0, m_status = 0, m_match = 0, m_score = 0, m_jobs = 0;
  int m_accept_cyc = 0;
  int n_accepts = 0, n_results = 0;
  bit m_done_now;

  always @(posedge clk) begin
    m_pa = 0;
    if (reset) begin
      m_ph = 0; m_age = 0; m_id = 0; m_to = 0;
      m_status = 0; m_match = 0; m_score = 0; m_jobs = 0;
    end else if (m_ph == 0) begin
      if (job_valid) begin
        m_id = int'(job_id); m_to = int'(cfg_timeout);
        m_status = 0; m_match = 0; m_score = 0;
        m_ph = 1; m_age = 0;
        m_accept_cyc = cyc;
        n_accepts++;
      end
    end else if (m_ph == 5) begin
      if (result_ready) begin
        m_ph = 0;
        if (m_jobs < 65535) m_jobs++;
        n_results++;
      end
    end else begin
      m_done_now = (m_ph == 1) ? fcreate : (m_ph == 2) ? finitialize :
                   (m_ph == 3) ? ftraceback : fverdict;
      if (abort) begin
        m_status = 2; m_pa = 1; m_ph = 5;
      end else if (m_age > 0 && m_done_now) begin
        if (m_ph == 4) begin
          m_match = int'(verdict_match); m_score = int'(verdict_score); m_status = 0;
        end
        m_ph++; m_age = 0;
      end else if (m_to != 0 && m_age == m_to) begin
        m_status = 1; m_pa = 1; m_ph = 5;
      end else begin
        m_age++;
      end
    end
    cyc++;
  end

  // ------------------------------------------------------------------
  // Compare process: every output, every cycle, on the falling edge.
  // Also records when observed DUT events happened.
  // ------------------------------------------------------------------
  int t_create = -1, t_trace = -1, t_pa = -1, t_rv = -1;
  int n_pa = 0, n_trace = 0;
  logic rv_prev = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("job_ready",     32'(job_ready),     32'(m_ph == 0));
      chk("busy",          32'(busy),          32'(m_ph != 0));
      chk("cur_phase",     32'(cur_phase),     32'(m_ph));
      chk("create_start",  32'(create_start),  32'(m_ph == 1 && m_age == 0));
      chk("init_start",    32'(init_start),    32'(m_ph == 2 && m_age == 0));
      chk("trace_start",   32'(trace_start),   32'(m_ph == 3 && m_age == 0));
      chk("verdict_start", 32'(verdict_start), 32'(m_ph == 4 && m_age == 0));
      chk("phase_abort",   32'(phase_abort),   32'(m_pa));
      chk("result_valid",  32'(result_valid),  32'(m_ph == 5));
      chk("result_id",     32'(result_id),     32'(m_id));
      chk("result_status", 32'(result_status), 32'(m_status));
      chk("result_match",  32'(result_match),  32'(m_match));
      chk("result_score",  32'(result_score),  32'(m_score));
      chk("jobs_done",     32'(jobs_done),     32'(m_jobs));
    end
    if (create_start === 1'b1) t_create = cyc;
    if (trace_start === 1'b1) begin t_trace = cyc; n_trace++; end
    if (phase_abort === 1'b1) begin t_pa = cyc; n_pa++; end
    if (result_valid === 1'b1 && rv_prev !== 1'b1) t_rv = cyc;
    rv_prev = result_valid;
  end

  // ------------------------------------------------------------------
  // Driver: phase-engine emulation and host behaviour
  // ------------------------------------------------------------------
  int dly[1:4];        // cycles after start at which done is raised, -1 = never
  int ab_ph = 0, ab_age = 0;
  bit noise = 0;
  int rr_mode = 1;     // 0 hold low, 1 hold high, 2 random
  bit v_rand = 0;
  bit v_match = 0;
  logic [SCORE_W-1:0] v_score = '0;

  function automatic logic eng(input int p);
    if (m_ph == p)
      return (dly[p] >= 1 && m_age == dly[p]) || (noise && m_age == 0 && $urandom_range(0, 1) == 1);
    return noise && ($urandom_range(0, 3) == 0);
  endfunction

  task automatic cycle();
    @(negedge clk);
    #1;
    fcreate     = eng(1);
    finitialize = eng(2);
    ftraceback  = eng(3);
    fverdict    = eng(4);
    abort = (ab_ph != 0 && ab_ph == m_ph && ab_age == m_age) ||
            (noise && (m_ph == 0 || m_ph == 5) && $urandom_range(0, 3) == 0);
    if (v_rand) begin
      verdict_match = 1'($urandom_range(0, 1));
      verdict_score = SCORE_W'($urandom);
    end else begin
      verdict_match = v_match;
      verdict_score = v_score;
    end
    result_ready = (rr_mode == 2) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
  endtask

  task automatic set_dly(input int a, input int b, input int c, input int d);
    dly[1] = a; dly[2] = b; dly[3] = c; dly[4] = d;
  endtask

  task automatic start_job(input int id, input int to);
    int a0;
    bit ok;
    a0 = n_accepts;
    ok = 0;
    job_id = ID_W'(id);
    cfg_timeout = TO_W'(to);
    job_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (n_accepts != a0) begin ok = 1; break; end
    end
    job_valid = 1'b0;
    if (!ok) expire("job_accept");
  endtask

  task automatic wait_ph(input int target, input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_ph == target) begin ok = 1; break; end
      cycle();
    end
    if (!ok) expire(name);
  endtask

  // ------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------
  initial begin
    set_dly(3, 3, 3, 3);

    // Reset
    reset = 1'b1;
    cycle();
    chk_en = 1;
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_jobs_done", 32'(jobs_done), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    cycle();

    // Nominal run
    rr_mode = 0; v_match = 1; v_score = 16'h0150;
    set_dly(3, 3, 3, 3);
    start_job(8'h2A, 100);
    wait_ph(5, 60, "nominal_report");
    chk("nom_id", 32'(result_id), 32'h2A);
    chk("nom_status", 32'(result_status), 32'd0);
    chk("nom_match", 32'(result_match), 32'd1);
    chk("nom_score", 32'(result_score), 32'h0150);
    rr_mode = 1;
    wait_ph(0, 10, "nominal_idle");
    cycle();
    chk("nom_jobs_done", 32'(jobs_done), 32'd1);

    // Minimum latency with immediate dones
    set_dly(1, 1, 1, 1);
    start_job(8'h11, 0);
    wait_ph(0, 40, "minlat_idle");
    chk("minlat_create", 32'(t_create - m_accept_cyc), 32'd1);
    chk("minlat_result", 32'(t_rv - m_accept_cyc), 32'd9);

    // Timeout in TRACE: decided at start+5, kill pulse visible one cycle later
    v_score = 16'h1234;
    set_dly(2, 2, -1, 2);
    rr_mode = 0;
    n_pa = 0;
    start_job(8'h21, 5);
    wait_ph(5, 60, "timeout_report");
    cycle();
    chk("to_pa_delay", 32'(t_pa - t_trace), 32'd6);
    chk("to_status", 32'(result_status), 32'd1);
    chk("to_score", 32'(result_score), 32'd0);
    chk("to_pa_count", 32'(n_pa), 32'd1);
    rr_mode = 1;
    wait_ph(0, 10, "timeout_idle");

    // Done on the last accepted cycle wins over the timeout
    set_dly(2, 2, 5, 2);
    rr_mode = 0;
    start_job(8'h22, 5);
    wait_ph(5, 60, "tolast_report");
    chk("tolast_status", 32'(result_status), 32'd0);
    chk("tolast_score", 32'(result_score), 32'h1234);
    rr_mode = 1;
    wait_ph(0, 10, "tolast_idle");

    // Abort together with finitialize
    set_dly(2, 3, 2, 2);
    ab_ph = 2; ab_age = 3;
    rr_mode = 0;
    n_pa = 0; n_trace = 0;
    start_job(8'h23, 50);
    wait_ph(5, 60, "abort_report");
    cycle();
    cycle();
    chk("ab_status", 32'(result_status), 32'd2);
    chk("ab_pa_count", 32'(n_pa), 32'd1);
    chk("ab_trace_count", 32'(n_trace), 32'd0);
    ab_ph = 0;
    rr_mode = 1;
    wait_ph(0, 10, "abort_idle");

    // Backpressure with a second job waiting
    set_dly(2, 2, 2, 2);
    v_score = 16'h0777;
    rr_mode = 0;
    start_job(8'h33, 50);
    wait_ph(5, 60, "bp_report");
    job_id = 8'h55;
    job_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("bp_job_ready", 32'(job_ready), 32'd0);
      chk("bp_id", 32'(result_id), 32'h33);
      chk("bp_score", 32'(result_score), 32'h0777);
    end
    rr_mode = 1;
    begin
      int a0;
      bit ok;
      a0 = n_accepts;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
        cycle();
        if (n_accepts != a0) begin ok = 1; break; end
      end
      job_valid = 1'b0;
      if (!ok) expire("bp_second_accept");
    end
    wait_ph(5, 60, "bp_second_report");
    chk("bp_second_id", 32'(result_id), 32'h55);
    wait_ph(0, 10, "bp_idle");

    // Reset in the middle of TRACE
    set_dly(2, 2, -1, 2);
    start_job(8'h44, 0);
    wait_ph(3, 40, "rstmid_trace");
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rstmid_phase", 32'(cur_phase), 32'd0);
    chk("rstmid_jobs", 32'(jobs_done), 32'd0);
    chk("rstmid_ready", 32'(job_ready), 32'd1);
    chk("rstmid_id", 32'(result_id), 32'd0);
    cycle();

    // Watchdog disabled, very slow create phase
    set_dly(70000, 2, 2, 2);
    v_score = 16'h0ABC;
    rr_mode = 0;
    n_pa = 0;
    start_job(8'h66, 0);
    wait_ph(5, 70100, "slow_report");
    chk("slow_status", 32'(result_status), 32'd0);
    chk("slow_pa_count", 32'(n_pa), 32'd0);
    rr_mode = 1;
    wait_ph(0, 10, "slow_idle");

    // Randomized jobs with noise, aborts and backpressure
    noise = 1; v_rand = 1; rr_mode = 2;
    for (int j = 0; j < 40; j++) begin
      int to;
      to = $urandom_range(0, 8);
      for (int p = 1; p <= 4; p++) begin
        dly[p] = $urandom_range(1, 10);
        if (to != 0 && $urandom_range(0, 5) == 0) dly[p] = -1;
      end
      ab_ph = $urandom_range(0, 7);
      ab_age = $urandom_range(0, 6);
      start_job(int'($urandom_range(0, 255)), to);
      wait_ph(0, 300, "rand_job");
    end
    noise = 0; ab_ph = 0;
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_time_limit cyc=%0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
